// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture controller: generates mic_clk, strobes captured bits to a decimator,
// discards warm-up samples and hands decimated samples to a consumer through a one-entry buffer.
module pdm_capture_ctrl #(
    parameter int unsigned DIV_HALF       = 4,
    parameter int unsigned WARMUP_SAMPLES = 64,
    parameter int unsigned DATA_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pdm_data_in,
    output logic              mic_clk,
    output logic              pdm_bit,
    output logic              pdm_bit_valid,
    output logic              dec_rst,
    input  logic [DATA_W-1:0] dec_sample,
    input  logic              dec_valid,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              clear_overrun,
    output logic [1:0]        state
);

    localparam logic [7:0] DivLast  = 8'(DIV_HALF - 1);
    localparam logic [9:0] WarmLast = 10'(WARMUP_SAMPLES - 1);
    localparam logic [9:0] WarmSat  = 10'(WARMUP_SAMPLES);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StWarmup = 2'b01,
        StRun    = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        div_cnt_q, div_cnt_d;
    logic              mic_clk_q, mic_clk_d;
    logic              pdm_bit_q, pdm_bit_d;
    logic              pdm_valid_q, pdm_valid_d;
    logic              dec_rst_q, dec_rst_d;
    logic [9:0]        warm_cnt_q, warm_cnt_d;
    logic [DATA_W-1:0] out_sample_q, out_sample_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              set_ovr;
    logic              take;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWarmup;
                end
            end
            StWarmup: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (dec_valid && (warm_cnt_q == WarmLast)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of all registered outputs and counters
    always_comb begin
        div_cnt_d    = div_cnt_q;
        mic_clk_d    = mic_clk_q;
        pdm_bit_d    = pdm_bit_q;
        pdm_valid_d  = 1'b0;
        dec_rst_d    = (state_d == StIdle);
        warm_cnt_d   = warm_cnt_q;
        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        set_ovr      = 1'b0;
        take         = 1'b0;

        if (state_d == StIdle) begin
            // Leaving or staying idle: park the mic clock and drop any pending sample
            div_cnt_d   = '0;
            mic_clk_d   = 1'b0;
            warm_cnt_d  = '0;
            out_valid_d = 1'b0;
        end else if (state_q != StIdle) begin
            if (div_cnt_q == DivLast) begin
                div_cnt_d = '0;
                mic_clk_d = ~mic_clk_q;
                if (mic_clk_q) begin
                    pdm_bit_d   = pdm_data_in;
                    pdm_valid_d = 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end

            if ((state_q == StWarmup) && dec_valid && (warm_cnt_q != WarmSat)) begin
                warm_cnt_d = warm_cnt_q + 10'd1;
            end

            if (state_q == StRun) begin
                take = dec_valid && (!out_valid_q || out_ready);
                if (take) begin
                    out_sample_d = dec_sample;
                    out_valid_d  = 1'b1;
                end else if (dec_valid) begin
                    set_ovr = 1'b1;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
        end

        // A new loss in the same cycle as a clear request keeps the flag set
        overrun_d = set_ovr | (overrun_q & ~clear_overrun);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            mic_clk_q    <= 1'b0;
            pdm_bit_q    <= 1'b0;
            pdm_valid_q  <= 1'b0;
            dec_rst_q    <= 1'b1;
            warm_cnt_q   <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            mic_clk_q    <= mic_clk_d;
            pdm_bit_q    <= pdm_bit_d;
            pdm_valid_q  <= pdm_valid_d;
            dec_rst_q    <= dec_rst_d;
            warm_cnt_q   <= warm_cnt_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign mic_clk       = mic_clk_q;
    assign pdm_bit       = pdm_bit_q;
    assign pdm_bit_valid = pdm_valid_q;
    assign dec_rst       = dec_rst_q;
    assign out_sample    = out_sample_q;
    assign out_valid     = out_valid_q;
    assign overrun       = overrun_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Bench for pdm_capture_ctrl: random stimulus, rule-level reference model and scoreboard queues.
module tb_pdm_capture_ctrl;

    localparam int DH = 4;
    localparam int WS = 64;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          pdm_data_in;
    logic          mic_clk;
    logic          pdm_bit;
    logic          pdm_bit_valid;
    logic          dec_rst;
    logic [DW-1:0] dec_sample;
    logic          dec_valid;
    logic [DW-1:0] out_sample;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          clear_overrun;
    logic [1:0]    state;

    pdm_capture_ctrl #(
        .DIV_HALF      (DH),
        .WARMUP_SAMPLES(WS),
        .DATA_W        (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pdm_data_in  (pdm_data_in),
        .mic_clk      (mic_clk),
        .pdm_bit      (pdm_bit),
        .pdm_bit_valid(pdm_bit_valid),
        .dec_rst      (dec_rst),
        .dec_sample   (dec_sample),
        .dec_valid    (dec_valid),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .clear_overrun(clear_overrun),
        .state        (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 warm-up, 2 run; m_n = clk edges since capture started
    int            m_mode;
    int            m_n;
    int            m_wc;
    bit            m_pend;
    bit            m_ovr;
    bit            pdm_q[$];
    logic [DW-1:0] smp_q[$];

    int            n_out = 0;
    int            last_out = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_n    = 0;
        m_wc   = 0;
        m_pend = 0;
        m_ovr  = 0;
        pdm_q.delete();
        smp_q.delete();
    endtask

    // Apply the inputs that were present at the clock edge just taken
    task automatic model_step();
        bit ovr_set;
        bit consumed;
        ovr_set = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_mode == 0) begin
            if (enable) begin
                m_mode = 1;
                m_n    = 0;
                m_wc   = 0;
            end
        end else if (!enable) begin
            // A pending sample not taken at this edge is thrown away
            if (m_pend && !out_ready && smp_q.size() > 0) void'(smp_q.pop_back());
            m_mode = 0;
            m_pend = 0;
        end else begin
            m_n++;
            if (m_n % (2 * DH) == 0) pdm_q.push_back(pdm_data_in);
            if (m_mode == 1) begin
                if (dec_valid) begin
                    m_wc++;
                    if (m_wc == WS) m_mode = 2;
                end
            end else begin
                consumed = m_pend && out_ready;
                if (dec_valid) begin
                    if (!m_pend || consumed) begin
                        smp_q.push_back(dec_sample);
                        m_pend = 1;
                    end else begin
                        ovr_set = 1;
                    end
                end else if (consumed) begin
                    m_pend = 0;
                end
            end
        end
        if (ovr_set) m_ovr = 1;
        else if (clear_overrun) m_ovr = 0;
    endtask

    task automatic cycle(input bit en, input bit dv, input logic [DW-1:0] ds, input bit rdy,
                         input bit clr);
        @(posedge clk);
        #1;
        model_step();
        enable        = en;
        dec_valid     = dv;
        dec_sample    = ds;
        out_ready     = rdy;
        clear_overrun = clr;
        pdm_data_in   = 1'($urandom_range(0, 1));
    endtask

    // Monitor: outputs sampled mid-cycle against the model and the scoreboard queues
    always @(negedge clk) begin
        check("state", int'(state), m_mode);
        check("mic_clk", int'(mic_clk), (m_mode != 0) ? ((m_n / DH) % 2) : 0);
        check("dec_rst", int'(dec_rst), (m_mode == 0) ? 1 : 0);
        check("pdm_bit_valid", int'(pdm_bit_valid),
              (m_mode != 0 && m_n > 0 && (m_n % (2 * DH)) == 0) ? 1 : 0);
        check("out_valid", int'(out_valid), int'(m_pend));
        check("overrun", int'(overrun), int'(m_ovr));
        if (pdm_bit_valid) begin
            if (pdm_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pdm_bit: strobe with no expected bit (t=%0t)", $time);
            end else begin
                check("pdm_bit", int'(pdm_bit), int'(pdm_q.pop_front()));
            end
        end
        if (out_valid) begin
            if (smp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_sample: valid with no expected sample (t=%0t)", $time);
            end else if (out_ready) begin
                check("out_sample", int'(out_sample), int'(smp_q.pop_front()));
                n_out++;
                last_out = int'(out_sample);
            end else begin
                check("out_sample_hold", int'(out_sample), int'(smp_q[0]));
            end
        end
    end

    initial begin
        int base;
        reset         = 1'b1;
        enable        = 1'b0;
        pdm_data_in   = 1'b0;
        dec_valid     = 1'b0;
        dec_sample    = '0;
        out_ready     = 1'b0;
        clear_overrun = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0, 0);
        check("rst_state", int'(state), 0);
        check("rst_mic_clk", int'(mic_clk), 0);
        check("rst_pdm_bit", int'(pdm_bit), 0);
        check("rst_pdm_bit_valid", int'(pdm_bit_valid), 0);
        check("rst_dec_rst", int'(dec_rst), 1);
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        cycle(0, 0, '0, 1, 0);

        // Decimator strobe every 32 clk with 1,2,3...; first 64 discarded
        base = n_out;
        for (int i = 0; i < (WS + 8) * 32; i++) cycle(1, (i % 32) == 31, DW'(i / 32 + 1), 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, 1, 0);
        check("warmup_delivered", n_out - base, 8);
        check("warmup_last", last_out, WS + 8);

        // Random traffic with back-pressure and occasional clears
        for (int i = 0; i < 1500; i++) begin
            cycle(1, $urandom_range(0, 5) == 0, DW'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0);
        end

        // Two samples while blocked: first kept, second lost
        cycle(1, 0, '0, 1, 1);
        cycle(1, 0, '0, 1, 0);
        cycle(1, 0, '0, 1, 0);
        cycle(1, 1, 16'hA5A5, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, 0);
        cycle(1, 1, 16'h5A5A, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, 0);
        check("ovr_sample", int'(out_sample), 16'hA5A5);
        check("ovr_valid", int'(out_valid), 1);
        check("ovr_flag", int'(overrun), 1);
        cycle(1, 1, 16'h1111, 0, 1);
        cycle(1, 0, '0, 0, 0);
        check("ovr_set_wins", int'(overrun), 1);
        cycle(1, 0, '0, 0, 1);
        cycle(1, 0, '0, 0, 0);
        check("ovr_cleared", int'(overrun), 0);

        // Consume and refill on the same edge
        cycle(1, 1, 16'h2222, 1, 0);
        cycle(1, 0, '0, 0, 0);
        check("refill_sample", int'(out_sample), 16'h2222);
        check("refill_valid", int'(out_valid), 1);
        check("refill_ovr", int'(overrun), 0);

        // Disable with a pending sample, then a full warm-up again
        cycle(0, 0, '0, 0, 0);
        cycle(0, 0, '0, 0, 0);
        check("dis_state", int'(state), 0);
        check("dis_out_valid", int'(out_valid), 0);
        check("dis_dec_rst", int'(dec_rst), 1);
        check("dis_mic_clk", int'(mic_clk), 0);
        base = n_out;
        for (int i = 0; i < (WS + 4) * 32; i++) cycle(1, (i % 32) == 31, DW'(i / 32 + 1), 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, 1, 0);
        check("rewarm_delivered", n_out - base, 4);
        check("rewarm_last", last_out, WS + 4);

        // Asynchronous reset between clock edges mid-run
        for (int i = 0; i < 200; i++) begin
            cycle(1, $urandom_range(0, 3) == 0, DW'($urandom), 1'($urandom_range(0, 1)), 0);
        end
        cycle(1, 1, 16'h3333, 0, 0);
        cycle(1, 1, 16'h4444, 0, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_state", int'(state), 0);
        check("arst_mic_clk", int'(mic_clk), 0);
        check("arst_pdm_bit", int'(pdm_bit), 0);
        check("arst_pdm_bit_valid", int'(pdm_bit_valid), 0);
        check("arst_dec_rst", int'(dec_rst), 1);
        check("arst_out_sample", int'(out_sample), 0);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_overrun", int'(overrun), 0);
        cycle(1, 0, '0, 1, 0);
        cycle(1, 0, '0, 1, 0);
        reset = 1'b0;
        cycle(1, 0, '0, 1, 0);
        check("arst_rewarm", int'(state), 1);
        for (int i = 0; i < 20; i++) cycle(1, 0, '0, 1, 0);
        check("queue_drained", smp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
